key_run_ctrl: RTL

//  Upstream control stage for the LED chaser. Synchronises and debounces one push-key.

---
 rtl/light_pkg.sv | 24 ++
 rtl/sync2.sv | 26 ++
 rtl/key_run_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/light_pkg.sv
// Shared constants for the LED chaser control path: key FSM state
// encodings and default debounce/long-press timings.
package light_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] DB_PRESS   = 3'd1;
    localparam logic [STATE_W-1:0] HELD       = 3'd2;
    localparam logic [STATE_W-1:0] LONG_HELD  = 3'd3;
    localparam logic [STATE_W-1:0] DB_RELEASE = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = IDLE,
        ST_DB_PRESS   = DB_PRESS,
        ST_HELD       = HELD,
        ST_LONG_HELD  = LONG_HELD,
        ST_DB_RELEASE = DB_RELEASE
    } key_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 1000;
    localparam int DEF_LONG_CYCLES     = 50000;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/key_run_ctrl.sv
// Push-key front end for the LED chaser: debounces the key, toggles the
// run enable on short presses and forces pause plus a clear on long ones.
module key_run_ctrl
    import light_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int   LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter logic KEY_ACTIVE_LOW  = 1'b1,
    parameter logic EN_RESET        = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic en,
    output logic press_pulse,
    output logic long_pulse,
    output logic key_level
);

    localparam int CW = $clog2(LONG_CYCLES + 1);

    localparam logic [CW-1:0] DB_LIM   = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LONG_LIM = CW'(LONG_CYCLES);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic kp;
    logic ks;

    key_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [CW-1:0] cnt_inc, hold_inc;
    logic          short_q, short_d;
    logic          en_q, en_d;
    logic          press_q, press_d;
    logic          long_q, long_d;
    logic          level_q, level_d;

    assign kp = key_in ^ KEY_ACTIVE_LOW;

    sync2 #(
        .RST_VAL (1'b0)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (kp),
        .q     (ks)
    );

    // Saturating increments: counters stick at all-ones, never wrap.
    assign cnt_inc  = (cnt_q == '1)  ? cnt_q  : cnt_q + ONE;
    assign hold_inc = (hold_q == '1) ? hold_q : hold_q + ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        short_d = short_q;
        en_d    = en_q;
        press_d = 1'b0;
        long_d  = 1'b0;
        level_d = level_q;

        unique case (state_q)
            ST_IDLE: begin
                if (ks) begin
                    state_d = ST_DB_PRESS;
                    cnt_d   = ONE;
                end
            end

            ST_DB_PRESS: begin
                if (!ks) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= DB_LIM) begin
                        state_d = ST_HELD;
                        hold_d  = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end
                end
            end

            // Long detection wins over a release seen on the same cycle.
            ST_HELD: begin
                hold_d = hold_inc;
                if (hold_inc >= LONG_LIM) begin
                    state_d = ST_LONG_HELD;
                    en_d    = 1'b0;
                    long_d  = 1'b1;
                end else if (!ks) begin
                    state_d = ST_DB_RELEASE;
                    cnt_d   = ONE;
                    short_d = 1'b1;
                end
            end

            ST_LONG_HELD: begin
                if (!ks) begin
                    state_d = ST_DB_RELEASE;
                    cnt_d   = ONE;
                    short_d = 1'b0;
                end
            end

            ST_DB_RELEASE: begin
                if (ks) begin
                    state_d = short_q ? ST_HELD : ST_LONG_HELD;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= DB_LIM) begin
                        state_d = ST_IDLE;
                        level_d = 1'b0;
                        if (short_q) begin
                            en_d = ~en_q;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            short_q <= 1'b0;
            en_q    <= EN_RESET;
            press_q <= 1'b0;
            long_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            short_q <= short_d;
            en_q    <= en_d;
            press_q <= press_d;
            long_q  <= long_d;
            level_q <= level_d;
        end
    end

    assign en          = en_q;
    assign press_pulse = press_q;
    assign long_pulse  = long_q;
    assign key_level   = level_q;

endmodule
